inst_issue_scheduler: RTL and testbench

Instruction queue and issue timer that sits in front of CONTROL_UNIT. It buffers instructions from the host or AXI side and presents them one at a time on the CU instruction bus. Each opcode is held for its required cycle count, and IDLE is driven whenever no instruction is due. It replaces bench-style hand timing (opcode held for N*clock_period) with hardware sequencing.

---
 rtl/inst_issue_scheduler.sv | 179 +++++++++++++++++
 tb/tb_inst_issue_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_issue_scheduler.sv
// Instruction FIFO plus issue timer in front of CONTROL_UNIT: presents one
// instruction at a time on inst_out, holding each for its opcode's cycle count.
module inst_issue_scheduler #(
    parameter int OPCODE_BITS           = 4,
    parameter int INST_BITS             = 148,
    parameter int DEPTH                 = 16,
    parameter int CNT_BITS              = 8,
    parameter int IDLE_OP               = 0,
    parameter int AXI_TO_UB_OP          = 1,
    parameter int AXI_TO_WB_OP          = 2,
    parameter int UB_TO_DATA_FIFO_OP    = 3,
    parameter int UB_TO_WEIGHT_FIFO_OP  = 4,
    parameter int MAT_MUL_OP            = 5,
    parameter int MAT_MUL_ACC_OP        = 6,
    parameter int IDLE_CYC              = 1,
    parameter int AXI_TO_UB_CYC         = 1,
    parameter int AXI_TO_WB_CYC         = 1,
    parameter int UB_TO_DATA_FIFO_CYC   = 2,
    parameter int UB_TO_WEIGHT_FIFO_CYC = 2,
    parameter int MAT_MUL_CYC           = 20,
    parameter int MAT_MUL_ACC_CYC       = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [INST_BITS-1:0]     in_inst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     pause,
    output logic [INST_BITS-1:0]     inst_out,
    output logic                     issue,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     err_opcode
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [INST_BITS-1:0] IDLE_WORD =
        {OPCODE_BITS'(IDLE_OP), {(INST_BITS-OPCODE_BITS){1'b0}}};

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

    // Timer load value is cyc-1; unknown opcodes and zero-cycle entries hold one cycle.
    function automatic logic [CNT_BITS-1:0] hold_load(input logic [OPCODE_BITS-1:0] op);
        int cyc;
        case (op)
            OPCODE_BITS'(IDLE_OP):              cyc = IDLE_CYC;
            OPCODE_BITS'(AXI_TO_UB_OP):         cyc = AXI_TO_UB_CYC;
            OPCODE_BITS'(AXI_TO_WB_OP):         cyc = AXI_TO_WB_CYC;
            OPCODE_BITS'(UB_TO_DATA_FIFO_OP):   cyc = UB_TO_DATA_FIFO_CYC;
            OPCODE_BITS'(UB_TO_WEIGHT_FIFO_OP): cyc = UB_TO_WEIGHT_FIFO_CYC;
            OPCODE_BITS'(MAT_MUL_OP):           cyc = MAT_MUL_CYC;
            OPCODE_BITS'(MAT_MUL_ACC_OP):       cyc = MAT_MUL_ACC_CYC;
            default:                            cyc = 32'sd1;
        endcase
        cyc = (cyc < 32'sd1) ? 32'sd1 : cyc;
        return CNT_BITS'(cyc - 32'sd1);
    endfunction

    function automatic logic op_defined(input logic [OPCODE_BITS-1:0] op);
        logic ok;
        case (op)
            OPCODE_BITS'(IDLE_OP),
            OPCODE_BITS'(AXI_TO_UB_OP),
            OPCODE_BITS'(AXI_TO_WB_OP),
            OPCODE_BITS'(UB_TO_DATA_FIFO_OP),
            OPCODE_BITS'(UB_TO_WEIGHT_FIFO_OP),
            OPCODE_BITS'(MAT_MUL_OP),
            OPCODE_BITS'(MAT_MUL_ACC_OP): ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [INST_BITS-1:0]   mem_r [DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [AW:0]            count_r;
    logic                   in_ready_r;
    state_t                 state_r;
    logic [CNT_BITS-1:0]    timer_r;
    logic [INST_BITS-1:0]   inst_out_r;
    logic                   issue_r;
    logic                   busy_r;
    logic                   err_r;

    logic                   push_s;
    logic                   pop_s;
    logic [AW:0]            count_nxt_s;
    logic [INST_BITS-1:0]   head_s;
    logic [OPCODE_BITS-1:0] head_op_s;

    // Handshake, pop decision and next occupancy.
    always_comb begin
        push_s      = in_valid && in_ready_r;
        head_s      = mem_r[rd_ptr_r];
        head_op_s   = head_s[INST_BITS-1 -: OPCODE_BITS];
        pop_s       = (count_r != {(AW+1){1'b0}}) && !pause &&
                      ((state_r == ST_IDLE) || (timer_r == {CNT_BITS{1'b0}}));
        count_nxt_s = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    end

    // Instruction storage; pointers reset separately so stale contents are harmless.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            mem_r[wr_ptr_r] <= in_inst;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r    <= count_nxt_s;
            in_ready_r <= (count_nxt_s != DEPTH_C);
        end
    end

    // Issue FSM: pop on a free slot, hold for the opcode's count, fall back to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            timer_r    <= {CNT_BITS{1'b0}};
            inst_out_r <= IDLE_WORD;
            issue_r    <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_HOLD: begin
                    if (pop_s) begin
                        state_r    <= ST_HOLD;
                        timer_r    <= hold_load(head_op_s);
                        inst_out_r <= head_s;
                        issue_r    <= 1'b1;
                        busy_r     <= 1'b1;
                        if (!op_defined(head_op_s)) begin
                            err_r <= 1'b1;
                        end
                    end else if ((state_r == ST_HOLD) && (timer_r != {CNT_BITS{1'b0}})) begin
                        timer_r <= timer_r - CNT_BITS'(1);
                        issue_r <= 1'b0;
                    end else begin
                        state_r    <= ST_IDLE;
                        timer_r    <= {CNT_BITS{1'b0}};
                        inst_out_r <= IDLE_WORD;
                        issue_r    <= 1'b0;
                        busy_r     <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    timer_r    <= {CNT_BITS{1'b0}};
                    inst_out_r <= IDLE_WORD;
                    issue_r    <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign inst_out   = inst_out_r;
    assign issue      = issue_r;
    assign busy       = busy_r;
    assign fifo_count = count_r;
    assign err_opcode = err_r;

endmodule

// File: tb/tb_inst_issue_scheduler.sv
// Directed bench for inst_issue_scheduler: inputs driven and outputs sampled on
// the falling edge, each check an immediate assertion against a hand-computed value.
module tb_inst_issue_scheduler;

    localparam int IB = 148;
    localparam logic [IB-1:0] IDLE_W = {IB{1'b0}};

    logic          clk = 1'b0;
    logic          reset;
    logic [IB-1:0] in_inst;
    logic          in_valid;
    logic          in_ready;
    logic          pause;
    logic [IB-1:0] inst_out;
    logic          issue;
    logic          busy;
    logic [4:0]    fifo_count;
    logic          err_opcode;

    int checks   = 0;
    int failures = 0;

    inst_issue_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .in_inst    (in_inst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pause      (pause),
        .inst_out   (inst_out),
        .issue      (issue),
        .busy       (busy),
        .fifo_count (fifo_count),
        .err_opcode (err_opcode)
    );

    always #5 clk = ~clk;

    function automatic logic [IB-1:0] mk(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [127:0] d);
        return {op, a, b, d};
    endfunction

    task automatic chk(input string tag, input logic [IB-1:0] obs, input logic [IB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    logic [IB-1:0] w_mm, w_a, w_b, w_c, w_m2, w_q, w_e, w_q2;

    initial begin
        w_mm = mk(4'd5, 8'd3, 8'd0, 128'h1111);
        w_a  = mk(4'd3, 8'd0, 8'd0, 128'h0a);
        w_b  = mk(4'd4, 8'd0, 8'd1, 128'h0b);
        w_c  = mk(4'd6, 8'd4, 8'd0, 128'h0c);
        w_m2 = mk(4'd5, 8'd5, 8'd0, 128'h2222);
        w_q  = mk(4'd2, 8'd7, 8'd0, 128'h3333);
        w_e  = mk(4'd15, 8'd9, 8'd9, 128'hdead);
        w_q2 = mk(4'd1, 8'd1, 8'd2, 128'h4444);

        reset = 1'b1; in_valid = 1'b0; pause = 1'b0; in_inst = IDLE_W;
        step();
        step();
        chk("rst_inst", inst_out, IDLE_W);
        chk("rst_in_ready", in_ready, 1'b1);
        reset = 1'b0;
        step();
        chk("idle_inst", inst_out, IDLE_W);
        chk("idle_busy", busy, 1'b0);
        chk("idle_issue", issue, 1'b0);
        chk("idle_count", fifo_count, 5'd0);
        chk("idle_in_ready", in_ready, 1'b1);
        chk("idle_err", err_opcode, 1'b0);

        // single MAT_MUL issue
        in_valid = 1'b1; in_inst = w_mm;
        step();
        in_valid = 1'b0;
        chk("single_queued", fifo_count, 5'd1);
        chk("single_not_yet", issue, 1'b0);
        step();
        chk("single_issue", issue, 1'b1);
        chk("single_inst", inst_out, w_mm);
        chk("single_busy", busy, 1'b1);
        chk("single_count", fifo_count, 5'd0);
        for (int i = 1; i < 20; i++) begin
            step();
            chk("single_hold", inst_out, w_mm);
            chk("single_hold_issue", issue, 1'b0);
            chk("single_hold_busy", busy, 1'b1);
        end
        step();
        chk("single_end_inst", inst_out, IDLE_W);
        chk("single_end_busy", busy, 1'b0);

        // back-to-back 2/2/20
        in_valid = 1'b1; in_inst = w_a;
        step();
        in_inst = w_b;
        step();
        chk("b2b_a_issue", issue, 1'b1);
        chk("b2b_a_inst", inst_out, w_a);
        in_inst = w_c;
        step();
        in_valid = 1'b0;
        chk("b2b_a_hold", inst_out, w_a);
        chk("b2b_a_hold_issue", issue, 1'b0);
        chk("b2b_count2", fifo_count, 5'd2);
        step();
        chk("b2b_b_issue", issue, 1'b1);
        chk("b2b_b_inst", inst_out, w_b);
        chk("b2b_count1", fifo_count, 5'd1);
        step();
        chk("b2b_b_hold", inst_out, w_b);
        chk("b2b_b_hold_issue", issue, 1'b0);
        step();
        chk("b2b_c_issue", issue, 1'b1);
        chk("b2b_c_inst", inst_out, w_c);
        chk("b2b_count0", fifo_count, 5'd0);
        for (int i = 1; i < 20; i++) begin
            step();
            chk("b2b_c_hold", inst_out, w_c);
            chk("b2b_c_hold_issue", issue, 1'b0);
        end
        step();
        chk("b2b_end_inst", inst_out, IDLE_W);
        chk("b2b_end_busy", busy, 1'b0);

        // fill FIFO while paused; 17th push dropped
        pause = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            in_inst = mk(4'd1, 8'd0, 8'd0, 128'(k));
            step();
            if (k == 15) begin
                chk("full_in_ready_at16", in_ready, 1'b0);
            end
        end
        in_valid = 1'b0;
        chk("full_count", fifo_count, 5'd16);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_paused_inst", inst_out, IDLE_W);
        pause = 1'b0;
        step();
        chk("drain_first", inst_out, mk(4'd1, 8'd0, 8'd0, 128'd0));
        chk("drain_first_issue", issue, 1'b1);
        chk("drain_count15", fifo_count, 5'd15);
        chk("drain_in_ready", in_ready, 1'b1);
        for (int k = 1; k < 16; k++) begin
            step();
            chk("drain_word", inst_out, mk(4'd1, 8'd0, 8'd0, 128'(k)));
            chk("drain_issue", issue, 1'b1);
        end
        step();
        chk("drain_end_inst", inst_out, IDLE_W);
        chk("drain_end_issue", issue, 1'b0);
        chk("drain_end_count", fifo_count, 5'd0);

        // pause during 5th hold cycle of MAT_MUL with one queued entry
        in_valid = 1'b1; in_inst = w_m2;
        step();
        in_inst = w_q;
        step();
        in_valid = 1'b0;
        chk("pause_mm_issue", issue, 1'b1);
        chk("pause_mm_inst", inst_out, w_m2);
        chk("pause_queued", fifo_count, 5'd1);
        step();
        step();
        step();
        pause = 1'b1;
        for (int i = 5; i <= 20; i++) begin
            step();
            chk("pause_mm_hold", inst_out, w_m2);
        end
        step();
        chk("pause_idle_inst", inst_out, IDLE_W);
        chk("pause_idle_busy", busy, 1'b0);
        chk("pause_idle_count", fifo_count, 5'd1);
        step();
        chk("pause_still_idle", inst_out, IDLE_W);
        pause = 1'b0;
        step();
        chk("resume_inst", inst_out, w_q);
        chk("resume_issue", issue, 1'b1);
        chk("resume_count", fifo_count, 5'd0);
        step();
        chk("resume_end", inst_out, IDLE_W);

        // undefined opcode, then reset mid-hold
        in_valid = 1'b1; in_inst = w_e;
        step();
        in_valid = 1'b0;
        chk("err_before", err_opcode, 1'b0);
        step();
        chk("err_inst", inst_out, w_e);
        chk("err_issue", issue, 1'b1);
        step();
        chk("err_one_cycle", inst_out, IDLE_W);
        chk("err_set", err_opcode, 1'b1);
        in_valid = 1'b1; in_inst = w_m2;
        step();
        in_inst = w_q2;
        step();
        in_valid = 1'b0;
        chk("err_sticky", err_opcode, 1'b1);
        chk("rst2_mm_inst", inst_out, w_m2);
        step();
        step();
        chk("rst2_queued", fifo_count, 5'd1);
        reset = 1'b1;
        step();
        chk("rst2_inst", inst_out, IDLE_W);
        chk("rst2_err", err_opcode, 1'b0);
        chk("rst2_count", fifo_count, 5'd0);
        chk("rst2_busy", busy, 1'b0);
        chk("rst2_in_ready", in_ready, 1'b1);
        reset = 1'b0;
        step();
        step();
        step();
        chk("rst2_lost_inst", inst_out, IDLE_W);
        chk("rst2_lost_issue", issue, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
